// File: rtl/nes_pad_poller.sv
// Periodic poller for NUM_PADS NES controllers sharing one latch/clock pair.
// Publishes per-frame button state, press-edge pulses with optional auto-repeat, and a sticky overrun flag.
module nes_pad_poller #(
    parameter int unsigned NUM_PADS     = 2,
    parameter int unsigned BIT_CYCLES   = 152,
    parameter int unsigned POLL_PERIOD  = 419583,
    parameter int unsigned REPEAT_DELAY = 30,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  poll_en,
    input  logic                  repeat_en,
    input  logic [NUM_PADS-1:0]   pad_data,
    output logic                  pad_latch,
    output logic                  pad_clk,
    output logic [8*NUM_PADS-1:0] buttons,
    output logic [8*NUM_PADS-1:0] pressed,
    output logic                  frame_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned HALF         = BIT_CYCLES / 2;
    localparam int unsigned LATCH_CYCLES = 2 * BIT_CYCLES;
    localparam int unsigned PW           = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned CW           = $clog2(LATCH_CYCLES);
    localparam int unsigned HOLD_MAX     = REPEAT_DELAY + REPEAT_RATE;
    localparam int unsigned HW           = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_PULSE_HI,
        S_PULSE_LO,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [PW-1:0]                period_q, period_d;
    logic [CW-1:0]                phase_q, phase_d;
    logic [2:0]                   bit_q, bit_d;
    logic [NUM_PADS-1:0][7:0]     capture_q, capture_d;
    logic [NUM_PADS-1:0][7:0]     buttons_q, buttons_d;
    logic [NUM_PADS-1:0][7:0]     pressed_q, pressed_d;
    logic                         frame_valid_q, frame_valid_d;
    logic                         overrun_q, overrun_d;
    logic [NUM_PADS-1:0][HW-1:0]  hold_q, hold_d, hold_next;
    logic [NUM_PADS-1:0][7:0]     rep_mask;
    logic                         tick;

    assign tick     = (period_q == PW'(POLL_PERIOD - 1));
    assign period_d = tick ? '0 : period_q + PW'(1);

    // Hold counter only advances while a non-zero vector repeats unchanged; reload spaces later repeats by REPEAT_RATE.
    always_comb begin
        hold_next = '0;
        rep_mask  = '0;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            if (capture_q[p] == buttons_q[p] && capture_q[p] != 8'h00) begin
                hold_next[p] = (hold_q[p] == HW'(HOLD_MAX)) ? hold_q[p] : hold_q[p] + HW'(1);
                if (repeat_en && hold_next[p] == HW'(REPEAT_DELAY)) begin
                    rep_mask[p]  = capture_q[p];
                    hold_next[p] = HW'(REPEAT_DELAY - REPEAT_RATE);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        bit_d         = bit_q;
        capture_d     = capture_q;
        buttons_d     = buttons_q;
        pressed_d     = '0;
        frame_valid_d = 1'b0;
        overrun_d     = overrun_q;
        hold_d        = hold_q;

        if (tick && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick && poll_en) begin
                    state_d = S_LATCH;
                    phase_d = '0;
                end
            end
            S_LATCH: begin
                if (phase_q == CW'(LATCH_CYCLES - 1)) begin
                    for (int unsigned p = 0; p < NUM_PADS; p++) begin
                        capture_d[p][0] = ~pad_data[p];
                    end
                    bit_d   = 3'd1;
                    phase_d = '0;
                    state_d = S_PULSE_HI;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            S_PULSE_HI: begin
                if (phase_q == CW'(HALF - 1)) begin
                    phase_d = '0;
                    state_d = S_PULSE_LO;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            S_PULSE_LO: begin
                if (phase_q == CW'(HALF - 1)) begin
                    for (int unsigned p = 0; p < NUM_PADS; p++) begin
                        capture_d[p][bit_q] = ~pad_data[p];
                    end
                    phase_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = S_PULSE_HI;
                    end
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d       = S_IDLE;
                buttons_d     = capture_q;
                frame_valid_d = 1'b1;
                hold_d        = hold_next;
                for (int unsigned p = 0; p < NUM_PADS; p++) begin
                    pressed_d[p] = (capture_q[p] & ~buttons_q[p]) | rep_mask[p];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            period_q      <= '0;
            phase_q       <= '0;
            bit_q         <= '0;
            capture_q     <= '0;
            buttons_q     <= '0;
            pressed_q     <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            phase_q       <= phase_d;
            bit_q         <= bit_d;
            capture_q     <= capture_d;
            buttons_q     <= buttons_d;
            pressed_q     <= pressed_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            hold_q        <= hold_d;
        end
    end

    assign pad_latch   = (state_q == S_LATCH);
    assign pad_clk     = (state_q == S_PULSE_HI);
    assign busy        = (state_q != S_IDLE);
    assign buttons     = buttons_q;
    assign pressed     = pressed_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Directed bench for nes_pad_poller: shift-register pad models feed the main instance,
// three short-period instances exercise overrun and back-to-back tick timing.
module tb_nes_pad_poller;

    logic        clk = 1'b0;
    logic        reset, reset_b;
    logic        poll_en, repeat_en;
    logic [1:0]  pad_data;
    logic        pad_latch, pad_clk, frame_valid, busy, overrun;
    logic [15:0] buttons, pressed;

    logic        latch_b, pclk_b, fv_b, busy_b, ovr_b;
    logic        latch_c, pclk_c, fv_c, busy_c, ovr_c;
    logic        latch_d, pclk_d, fv_d, busy_d, ovr_d;
    logic [15:0] btn_b, prs_b, btn_c, prs_c, btn_d, prs_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nes_pad_poller #(.NUM_PADS(2), .BIT_CYCLES(4), .POLL_PERIOD(100), .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut (
        .clk(clk), .reset(reset), .poll_en(poll_en), .repeat_en(repeat_en), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons), .pressed(pressed),
        .frame_valid(frame_valid), .busy(busy), .overrun(overrun));

    nes_pad_poller #(.NUM_PADS(2), .BIT_CYCLES(4), .POLL_PERIOD(20)) dut_b (
        .clk(clk), .reset(reset_b), .poll_en(1'b1), .repeat_en(1'b0), .pad_data(2'b11),
        .pad_latch(latch_b), .pad_clk(pclk_b), .buttons(btn_b), .pressed(prs_b),
        .frame_valid(fv_b), .busy(busy_b), .overrun(ovr_b));

    nes_pad_poller #(.NUM_PADS(2), .BIT_CYCLES(4), .POLL_PERIOD(37)) dut_c (
        .clk(clk), .reset(reset_b), .poll_en(1'b1), .repeat_en(1'b0), .pad_data(2'b11),
        .pad_latch(latch_c), .pad_clk(pclk_c), .buttons(btn_c), .pressed(prs_c),
        .frame_valid(fv_c), .busy(busy_c), .overrun(ovr_c));

    nes_pad_poller #(.NUM_PADS(2), .BIT_CYCLES(4), .POLL_PERIOD(38)) dut_d (
        .clk(clk), .reset(reset_b), .poll_en(1'b1), .repeat_en(1'b0), .pad_data(2'b11),
        .pad_latch(latch_d), .pad_clk(pclk_d), .buttons(btn_d), .pressed(prs_d),
        .frame_valid(fv_d), .busy(busy_d), .overrun(ovr_d));

    // 4021-style pads: parallel load while latched, shift on pad_clk rise, ones shift in.
    logic [7:0] btn0, btn1;
    logic [7:0] sreg0 = 8'hFF;
    logic [7:0] sreg1 = 8'hFF;
    logic       pclk_prev = 1'b0;

    always @(posedge clk) begin
        pclk_prev <= pad_clk;
        if (pad_latch) begin
            sreg0 <= ~btn0;
            sreg1 <= ~btn1;
        end else if (pad_clk && !pclk_prev) begin
            sreg0 <= {1'b1, sreg0[7:1]};
            sreg1 <= {1'b1, sreg1[7:1]};
        end
    end
    assign pad_data = {sreg1[0], sreg0[0]};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (frame_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset_b = 1'b1; poll_en = 1'b1; repeat_en = 1'b0; btn0 = 8'h00; btn1 = 8'h00;
        repeat (3) step();
        n_checks++; if ({pad_latch, pad_clk, frame_valid, busy, overrun} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {pad_latch, pad_clk, frame_valid, busy, overrun}); end
        n_checks++; if ({buttons, pressed} !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", {buttons, pressed}); end
    endtask

    task automatic test_first_poll();
        logic [3:0] exp_sig;
        int rises;
        logic prev;
        rises = 0; prev = 1'b0;
        reset = 1'b0;
        for (int c = 1; c <= 137; c++) begin
            step();
            exp_sig = {c >= 100 && c < 108, c >= 108 && c < 136 && ((c - 108) % 4) < 2, c >= 100 && c <= 136, c == 137};
            n_checks++; if ({pad_latch, pad_clk, busy, frame_valid} !== exp_sig) begin n_fail++; $display("FAIL first_poll_wave cycle %0d: got %b expected %b", c, {pad_latch, pad_clk, busy, frame_valid}, exp_sig); end
            if (pad_clk && !prev) rises++;
            prev = pad_clk;
        end
        n_checks++; if (rises !== 7) begin n_fail++; $display("FAIL clk_pulses: got %0d expected 7", rises); end
        n_checks++; if ({buttons, pressed} !== 32'h0) begin n_fail++; $display("FAIL idle_pads: got %h expected 00000000", {buttons, pressed}); end
    endtask

    task automatic test_buttons();
        bit ok;
        btn0 = 8'h11; btn1 = 8'h08;
        wait_frame(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL btn_frame1: got timeout expected frame_valid"); end
        n_checks++; if (buttons !== 16'h0811) begin n_fail++; $display("FAIL btn_held1: got %h expected 0811", buttons); end
        n_checks++; if (pressed !== 16'h0811) begin n_fail++; $display("FAIL btn_pressed1: got %h expected 0811", pressed); end
        step();
        n_checks++; if ({frame_valid, pressed} !== 17'h0) begin n_fail++; $display("FAIL pulse_width: got %h expected 00000", {frame_valid, pressed}); end
        wait_frame(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL btn_frame2: got timeout expected frame_valid"); end
        n_checks++; if (buttons !== 16'h0811) begin n_fail++; $display("FAIL btn_held2: got %h expected 0811", buttons); end
        n_checks++; if (pressed !== 16'h0000) begin n_fail++; $display("FAIL btn_pressed2: got %h expected 0000", pressed); end
    endtask

    task automatic test_repeat();
        bit ok;
        logic [7:0] pat;
        logic [15:0] exp_p;
        repeat_en = 1'b1; btn0 = 8'h80; btn1 = 8'h00;
        pat = 8'b1010_1001;
        for (int i = 0; i < 8; i++) begin
            wait_frame(200, ok);
            exp_p = pat[i] ? 16'h0080 : 16'h0000;
            n_checks++; if (!ok || pressed !== exp_p || buttons !== 16'h0080) begin n_fail++; $display("FAIL repeat_on poll %0d: got ok=%0b pressed=%h buttons=%h expected pressed=%h buttons=0080", i + 1, ok, pressed, buttons, exp_p); end
        end
        btn0 = 8'h00;
        wait_frame(200, ok);
        n_checks++; if (!ok || {buttons, pressed} !== 32'h0) begin n_fail++; $display("FAIL release: got ok=%0b %h expected 00000000", ok, {buttons, pressed}); end
        btn0 = 8'h80;
        wait_frame(200, ok);
        n_checks++; if (!ok || pressed !== 16'h0080) begin n_fail++; $display("FAIL repress: got ok=%0b pressed=%h expected 0080", ok, pressed); end
        wait_frame(200, ok);
        n_checks++; if (!ok || pressed !== 16'h0000) begin n_fail++; $display("FAIL repress_hold: got ok=%0b pressed=%h expected 0000", ok, pressed); end
        repeat_en = 1'b0; btn0 = 8'h00;
        wait_frame(200, ok);
        n_checks++; if (!ok || pressed !== 16'h0000) begin n_fail++; $display("FAIL release2: got ok=%0b pressed=%h expected 0000", ok, pressed); end
        btn0 = 8'h80;
        pat = 8'b0000_0001;
        for (int i = 0; i < 8; i++) begin
            wait_frame(200, ok);
            exp_p = pat[i] ? 16'h0080 : 16'h0000;
            n_checks++; if (!ok || pressed !== exp_p) begin n_fail++; $display("FAIL repeat_off poll %0d: got ok=%0b pressed=%h expected %h", i + 1, ok, pressed, exp_p); end
        end
    endtask

    task automatic test_reset_midpoll();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (pad_latch) ok = 1'b1;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midpoll_latch: got timeout expected pad_latch"); end
        repeat (16) step();
        n_checks++; if ({pad_latch, pad_clk, buttons} !== {2'b01, 16'h0080}) begin n_fail++; $display("FAIL bit3_hi: got %b %h expected 01 0080", {pad_latch, pad_clk}, buttons); end
        reset = 1'b1;
        step();
        n_checks++; if ({pad_latch, pad_clk, busy, frame_valid, buttons, pressed} !== 36'h0) begin n_fail++; $display("FAIL midpoll_abort: got %h expected 000000000", {pad_latch, pad_clk, busy, frame_valid, buttons, pressed}); end
        step();
        reset = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            step();
            n_checks++; if ({pad_latch, frame_valid} !== {c == 100, 1'b0}) begin n_fail++; $display("FAIL resume cycle %0d: got %b expected %b", c, {pad_latch, frame_valid}, {c == 100, 1'b0}); end
        end
        wait_frame(200, ok);
        n_checks++; if (!ok || buttons !== 16'h0080 || pressed !== 16'h0080) begin n_fail++; $display("FAIL resume_frame: got ok=%0b buttons=%h pressed=%h expected 0080 0080", ok, buttons, pressed); end
    endtask

    task automatic test_poll_en();
        bit ok;
        int rises;
        logic prev;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (pad_latch) ok = 1'b1;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pe_latch: got timeout expected pad_latch"); end
        poll_en = 1'b0;
        rises = 0; prev = 1'b1;
        for (int c = 1; c <= 350; c++) begin
            step();
            if (pad_latch && !prev) rises++;
            prev = pad_latch;
        end
        n_checks++; if (rises !== 0 || overrun !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL pe_disabled: got rises=%0d overrun=%b busy=%b expected 0 0 0", rises, overrun, busy); end
        poll_en = 1'b1;
        repeat (49) step();
        n_checks++; if (pad_latch !== 1'b0) begin n_fail++; $display("FAIL pe_early: got %b expected 0", pad_latch); end
        step();
        n_checks++; if (pad_latch !== 1'b1) begin n_fail++; $display("FAIL pe_restart: got %b expected 1", pad_latch); end
    endtask

    task automatic test_overrun();
        int rises, frames;
        logic prev;
        rises = 0; frames = 0; prev = 1'b0;
        step();
        reset_b = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (latch_b && !prev) rises++;
            prev = latch_b;
            if (fv_b) frames++;
            if (c == 39) begin n_checks++; if (ovr_b !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b expected 0", ovr_b); end end
            if (c == 40) begin n_checks++; if ({ovr_b, busy_b} !== 2'b11) begin n_fail++; $display("FAIL ovr_set: got %b expected 11", {ovr_b, busy_b}); end end
            if (c == 73) begin n_checks++; if (ovr_c !== 1'b0) begin n_fail++; $display("FAIL done_tick_pre: got %b expected 0", ovr_c); end end
            if (c == 74) begin n_checks++; if ({fv_c, ovr_c} !== 2'b11) begin n_fail++; $display("FAIL done_tick: got %b expected 11", {fv_c, ovr_c}); end end
            if (c == 75) begin n_checks++; if ({fv_d, latch_d} !== 2'b10) begin n_fail++; $display("FAIL idle_tick_pre: got %b expected 10", {fv_d, latch_d}); end end
            if (c == 76) begin n_checks++; if ({latch_d, ovr_d} !== 2'b10) begin n_fail++; $display("FAIL idle_tick: got %b expected 10", {latch_d, ovr_d}); end end
        end
        n_checks++; if (rises !== 5 || frames !== 4) begin n_fail++; $display("FAIL ovr_polls: got rises=%0d frames=%0d expected 5 4", rises, frames); end
        n_checks++; if ({ovr_b, ovr_d} !== 2'b10) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 10", {ovr_b, ovr_d}); end
        reset_b = 1'b1;
        step();
        n_checks++; if ({ovr_b, ovr_c} !== 2'b00) begin n_fail++; $display("FAIL ovr_clear: got %b expected 00", {ovr_b, ovr_c}); end
    endtask

    initial begin
        test_reset();
        test_first_poll();
        test_buttons();
        test_repeat();
        test_reset_midpoll();
        test_poll_en();
        test_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/nes_pad_poller.md
Name: nes_pad_poller

Overview:
- Parametrised NES controller poller. Replaces the fixed two-controller, four-button read path in the pong datapath.
- Drives one shared latch/clock pair to NUM_PADS controllers and shifts all 8 buttons from every pad in parallel. It polls periodically and publishes debounced-by-frame button state.
- Adds features the old path lacked: per-pad press-edge pulses, optional auto-repeat for held buttons, and a poll-overrun flag.
- Sits between the controller pins and game logic (paddle/ball control).

Parameters:
- NUM_PADS, 2: number of controllers sharing latch/clock.
- BIT_CYCLES, 152: clk cycles per NES bit (6 us at 25.175 MHz). Must be even and >= 4.
- POLL_PERIOD, 419583: clk cycles between poll starts (60 Hz).
- REPEAT_DELAY, 30: polls a non-zero button vector must persist before the first repeat.
- REPEAT_RATE, 6: polls between subsequent repeats.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- poll_en  in  1  enables starting new polls.
- repeat_en  in  1  enables auto-repeat pulses on pressed.
- pad_data  in  NUM_PADS  serial data from each pad, active-low.
- pad_latch  out  1  shared latch to all pads.
- pad_clk  out  1  shared shift clock to all pads.
- buttons  out  8*NUM_PADS  held state, 1 = pressed. Pad p occupies bits [8p+7:8p]. Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- pressed  out  8*NUM_PADS  one-cycle pulses, same packing as buttons.
- frame_valid  out  1  one-cycle strobe; buttons and pressed are updated on this cycle.
- busy  out  1  high while the FSM is not in IDLE.
- overrun  out  1  sticky; set when a poll tick arrives while busy.

Behaviour:
- Reset values: all outputs 0, period counter 0, FSM in IDLE, hold counters 0. Reset asserted mid-poll aborts immediately: latch and clock drop to 0 on the next cycle and captured bits are discarded.
- Period counter:
  - Free-runs 0..POLL_PERIOD-1 and wraps to 0. The cycle where count == POLL_PERIOD-1 is the tick.
  - First tick occurs POLL_PERIOD cycles after reset deasserts.
- Tick handling:
  - Tick with poll_en=1 and FSM in IDLE: start a poll.
  - Tick with poll_en=0: ignored.
  - Tick while busy: ignored and overrun<=1. overrun clears only on reset.
- FSM states IDLE, LATCH, PULSE_HI, PULSE_LO, DONE. H = BIT_CYCLES/2.
  - IDLE: pad_latch=0, pad_clk=0.
  - LATCH: pad_latch=1 for 2*BIT_CYCLES cycles. On the last LATCH cycle, sample bit 0 from every pad: capture[p][0] = ~pad_data[p].
  - PULSE_HI: pad_clk=1 for H cycles.
  - PULSE_LO: pad_clk=0 for H cycles. On the last cycle, sample bit k (k = 1..7).
  - After bit 7: go to DONE; otherwise return to PULSE_HI.
  - DONE: 1 cycle, then IDLE.
  - Total poll length: 9*BIT_CYCLES + 1 cycles. Exactly 7 pad_clk pulses per poll.
- Outputs, on the clock edge that exits DONE:
  - buttons <= capture.
  - frame_valid <= 1 for exactly 1 cycle.
  - pressed[p] <= (capture[p] & ~old_buttons[p]) | repeat_mask[p]. Pulse lasts 1 cycle, coincident with frame_valid.
- Auto-repeat, evaluated per pad at DONE:
  - If capture[p] == old_buttons[p] and capture[p] != 0, hold[p] increments (saturates at REPEAT_DELAY+REPEAT_RATE). Otherwise hold[p] = 0.
  - When repeat_en=1 and the incremented hold[p] == REPEAT_DELAY, repeat_mask[p] = capture[p] and hold[p] is reloaded to REPEAT_DELAY-REPEAT_RATE. This yields a repeat every REPEAT_RATE polls thereafter. Otherwise repeat_mask[p] = 0.
- Simultaneous events:
  - A tick on the DONE cycle counts as busy (overrun).
  - A tick on the first IDLE cycle after DONE starts a new poll.
- Pads are independent. A pad whose data is floating high reads all-released.

Test Plan:
- Config BIT_CYCLES=4, POLL_PERIOD=100, NUM_PADS=2. Release reset and hold pad_data=2'b11 -> first pad_latch rise at cycle 100. Latch high 8 cycles, 7 pad_clk pulses each 2 high/2 low, frame_valid at cycle 137, buttons=0, busy low afterward.
- Pad0 drives A and Up low (bits 0 and 4 on their slots), pad1 drives Start low -> buttons=16'h0811 on frame_valid, pressed=16'h0811 in the same cycle. Same stimulus next poll -> buttons unchanged, pressed=0.
- REPEAT_DELAY=3, REPEAT_RATE=2, repeat_en=1, pad0 holds Right (bit 7) -> pressed[7] pulses at polls 1, 4, 6, 8. Releasing for one poll resets hold; re-press pulses immediately. With repeat_en=0, only poll 1 pulses.
- POLL_PERIOD=20 (shorter than 37-cycle poll) -> overrun=1 after the second tick. Polls still complete and every other tick starts a poll. Only reset clears overrun.
- Assert reset during PULSE_HI of bit 3 -> next cycle pad_latch=0, pad_clk=0, buttons=0, no frame_valid. Normal poll resumes 100 cycles after release.
- poll_en=0 across three ticks -> no latch activity and no overrun. Re-enable -> poll starts at the next tick.
